mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-master (fetch/data) arbiter in front of the single-port memory; holds the granted command for the whole transaction.
// Latency: request sampled in IDLE drives mem strobes next cycle; resp/rdata forwarded combinationally; one COOLDOWN cycle follows.
// Backpressure: masters hold requests until their resp; MEM_ARBITER_ROUND_ROBIN_EN swaps fixed data priority for alternation.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_read,
    input  logic [ADDR_W-1:0]   i_address,
    output logic                i_resp,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [DATA_W/8-1:0] d_byte_enable,
    input  logic [ADDR_W-1:0]   d_address,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_resp,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_read,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_byte_enable,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_resp,
    input  logic [DATA_W-1:0]   mem_rdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_I   = 2'd1,
        BUSY_D   = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  grant_i;
    logic                  grant_d;
    logic                  d_req;
    logic                  busy;

    logic                  cmd_read;
    logic                  cmd_write;
    logic [DATA_W/8-1:0]   cmd_be;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [DATA_W-1:0]     cmd_wdata;

    assign d_req = d_read | d_write;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // 1 = data port won the most recent grant
    logic last_grant_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_d <= 1'b0;
        end else if (grant_d) begin
            last_grant_d <= 1'b1;
        end else if (grant_i) begin
            last_grant_d <= 1'b0;
        end
    end

    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state_q == IDLE) begin
            grant_d = d_req & (~i_read | ~last_grant_d);
            grant_i = i_read & ~grant_d;
        end
    end
`else
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state_q == IDLE) begin
            grant_d = d_req;
            grant_i = i_read & ~d_req;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = BUSY_D;
                end else if (grant_i) begin
                    state_d = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_resp) begin
                    state_d = COOLDOWN;
                end
            end
            COOLDOWN: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cmd_read  <= 1'b0;
            cmd_write <= 1'b0;
            cmd_be    <= '0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else begin
            state_q <= state_d;
            if (grant_d) begin
                // simultaneous read+write is treated as a write
                cmd_read  <= d_read & ~d_write;
                cmd_write <= d_write;
                cmd_be    <= d_byte_enable;
                cmd_addr  <= d_address;
                cmd_wdata <= d_wdata;
            end else if (grant_i) begin
                cmd_read  <= 1'b1;
                cmd_write <= 1'b0;
                cmd_be    <= '1;
                cmd_addr  <= i_address;
                cmd_wdata <= '0;
            end
        end
    end

    assign busy            = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign mem_read        = busy & cmd_read;
    assign mem_write       = busy & cmd_write;
    assign mem_byte_enable = cmd_be;
    assign mem_address     = cmd_addr;
    assign mem_wdata       = cmd_wdata;

    assign i_resp  = (state_q == BUSY_I) & mem_resp;
    assign d_resp  = (state_q == BUSY_D) & mem_resp;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule
